// File: rtl/led_breath_pkg.sv
// rtl/led_breath_pkg.sv - shared state encoding, parameter defaults and duty helper for led_breath
package led_breath_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_e;

    localparam int PWM_BITS_DEF     = 4;
    localparam int STEP_PERIODS_DEF = 2;

    function automatic int duty_max(input int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/led_breath_pwm_core.sv
// rtl/led_breath_pwm_core.sv - tick-enabled PWM counter with wrap detect and registered compare
module pwm_core #(
    parameter int PWM_BITS = 4
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                active,
    input  logic                tick_in,
    input  logic [PWM_BITS-1:0] duty,
    output logic                led_out,
    output logic                wrap
);

    localparam int                  CNT_MAX_I = (1 << PWM_BITS) - 1;
    localparam logic [PWM_BITS-1:0] CNT_MAX   = CNT_MAX_I[PWM_BITS-1:0];
    localparam logic [PWM_BITS-1:0] ONE       = {{(PWM_BITS-1){1'b0}}, 1'b1};

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                led_q, led_d;

    // Leaving the active states clears the counter so a restart begins a fresh period.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q;
        if (!active) begin
            pwm_cnt_d = '0;
        end else if (tick_in) begin
            pwm_cnt_d = pwm_cnt_q + ONE;
        end
        led_d = active && (pwm_cnt_q < duty);
    end

    assign wrap    = active && tick_in && (pwm_cnt_q == CNT_MAX);
    assign led_out = led_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwm_cnt_q <= '0;
            led_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
        end
    end

endmodule

// File: rtl/led_breath.sv
// rtl/led_breath.sv - triangle-ramped LED breathing controller driving a tick-enabled PWM core
module led_breath
    import led_breath_pkg::*;
#(
    parameter int PWM_BITS     = PWM_BITS_DEF,
    parameter int STEP_PERIODS = STEP_PERIODS_DEF
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                tick_in,
    input  logic                en,
    output logic                led_out,
    output logic [PWM_BITS-1:0] duty_out,
    output logic                period_done
);

    localparam int                  DUTY_MAX_I  = duty_max(PWM_BITS);
    localparam logic [PWM_BITS-1:0] DUTY_MAX    = DUTY_MAX_I[PWM_BITS-1:0];
    localparam logic [PWM_BITS-1:0] ONE         = {{(PWM_BITS-1){1'b0}}, 1'b1};
    localparam int                  STEP_LAST_I = STEP_PERIODS - 1;
    localparam logic [7:0]          STEP_LAST   = STEP_LAST_I[7:0];

    state_e              state_q;
    logic [7:0]          step_cnt_q;
    logic [PWM_BITS-1:0] duty_q;
    logic                period_done_q;
    logic                active;
    logic                wrap;

    // Dropping en takes effect on the same edge, so the PWM core never sees that edge's tick.
    assign active = (state_q != IDLE) && en;

    pwm_core #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_core (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .active    (active),
        .tick_in   (tick_in),
        .duty      (duty_q),
        .led_out   (led_out),
        .wrap      (wrap)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= IDLE;
            step_cnt_q    <= '0;
            duty_q        <= '0;
            period_done_q <= 1'b0;
        end else begin
            period_done_q <= wrap;
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= UP;
                    end
                end
                UP, DOWN: begin
                    if (!en) begin
                        state_q    <= IDLE;
                        step_cnt_q <= '0;
                        duty_q     <= '0;
                    end else if (wrap) begin
                        if (step_cnt_q == STEP_LAST) begin
                            step_cnt_q <= '0;
                            // Extremes turn around rather than wrap, so each is held one step.
                            if (state_q == UP) begin
                                if (duty_q == DUTY_MAX) begin
                                    state_q <= DOWN;
                                    duty_q  <= DUTY_MAX - ONE;
                                end else begin
                                    duty_q <= duty_q + ONE;
                                end
                            end else begin
                                if (duty_q == '0) begin
                                    state_q <= UP;
                                    duty_q  <= ONE;
                                end else begin
                                    duty_q <= duty_q - ONE;
                                end
                            end
                        end else begin
                            step_cnt_q <= step_cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign duty_out    = duty_q;
    assign period_done = period_done_q;

endmodule

// File: tb/tb_led_breath.sv
// tb/tb_led_breath.sv - directed scoreboard bench for led_breath at default parameters
module tb_led_breath;

    localparam int PER  = 16;
    localparam int SP   = 2;
    localparam int DMAX = 15;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       tick_in;
    logic       en;
    logic       led_out;
    logic [3:0] duty_out;
    logic       period_done;

    led_breath dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .tick_in     (tick_in),
        .en          (en),
        .led_out     (led_out),
        .duty_out    (duty_out),
        .period_done (period_done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [5:0] exp_q[$];
    bit         m_act;
    int         m_n;
    logic       m_led;
    logic       m_pd;

    int         cnt_led1, cnt_led0, cnt_pd, cnt_chg, max_duty;
    logic [3:0] prev_duty;

    // Reference duty as a closed-form triangle of the number of counted ticks.
    function automatic logic [3:0] tri_duty(input int n);
        int s;
        s = (n / (PER * SP)) % (2 * DMAX);
        if (s <= DMAX) return 4'(s);
        return 4'(2 * DMAX - s);
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic clear_mon();
        cnt_led1  = 0;
        cnt_led0  = 0;
        cnt_pd    = 0;
        cnt_chg   = 0;
        max_duty  = 0;
        prev_duty = duty_out;
    endtask

    task automatic cyc(input logic t, input logic e);
        logic [5:0] exp_v;
        logic [5:0] got;
        tick_in = t;
        en      = e;
        if (!sys_rst_n) begin
            m_act = 0; m_n = 0; m_led = 0; m_pd = 0;
        end else if (!m_act) begin
            m_act = e; m_led = 0; m_pd = 0;
        end else if (!e) begin
            m_act = 0; m_n = 0; m_led = 0; m_pd = 0;
        end else begin
            m_led = (m_n % PER) < int'(tri_duty(m_n));
            m_pd  = t && ((m_n % PER) == PER - 1);
            if (t) m_n++;
        end
        exp_q.push_back({m_led, m_pd, tri_duty(m_n)});
        @(posedge sys_clk);
        #1;
        got   = {led_out, period_done, duty_out};
        exp_v = exp_q.pop_front();
        n_cmp++;
        assert (got === exp_v) else begin
            n_fail++;
            $error("FAIL cycle_outputs observed=%b expected=%b (led,pd,duty) at %0t", got, exp_v, $time);
        end
        if (led_out && duty_out == 4'd1) cnt_led1++;
        if (led_out && duty_out == 4'd0) cnt_led0++;
        if (period_done) cnt_pd++;
        if (duty_out != prev_duty) cnt_chg++;
        if (int'(duty_out) > max_duty) max_duty = int'(duty_out);
        prev_duty = duty_out;
    endtask

    initial begin
        int k;
        sys_rst_n = 1'b0;
        tick_in   = 1'b0;
        en        = 1'b0;
        m_act = 0; m_n = 0; m_led = 0; m_pd = 0;
        clear_mon();

        repeat (2) cyc(1'b1, 1'b1);
        chk("reset_state", int'({led_out, period_done, duty_out}), 0);
        sys_rst_n = 1'b1;

        cyc(1'b0, 1'b1);
        clear_mon();
        for (int i = 1; i <= 64; i++) begin
            cyc(1'b1, 1'b1);
            if (i == 16) chk("pd_after_tick16", int'(period_done), 1);
            if (i == 32) chk("pd_after_tick32", int'(period_done), 1);
            if (i == 32) chk("duty_after_tick32", int'(duty_out), 1);
            if (i == 64) chk("duty_after_tick64", int'(duty_out), 2);
            repeat (5) cyc(1'b0, 1'b1);
        end
        chk("led_high_clocks_duty1", cnt_led1, 6 * SP);

        k = 0;
        while (duty_out != 4'd7 && k < 400) begin
            cyc(1'b1, 1'b1);
            repeat (5) cyc(1'b0, 1'b1);
            k++;
        end
        chk("reach_duty7", int'(duty_out), 7);
        cyc(1'b1, 1'b0);
        chk("en_drop_outputs", int'({led_out, period_done, duty_out}), 0);
        cyc(1'b1, 1'b0);

        cyc(1'b0, 1'b1);
        clear_mon();
        k = 0;
        while (!period_done && k < 40) begin
            cyc(1'b1, 1'b1);
            k++;
        end
        chk("ticks_to_first_pd", k, 16);
        repeat (PER * SP * 2 * DMAX - 16) cyc(1'b1, 1'b1);
        chk("breath_pd_count", cnt_pd, 2 * DMAX * SP);
        chk("breath_duty_changes", cnt_chg, 2 * DMAX);
        chk("breath_max_duty", max_duty, DMAX);
        chk("led_high_at_duty0", cnt_led0, 0);
        chk("breath_end_duty", int'(duty_out), 0);

        repeat (100) cyc(1'b1, 1'b1);
        chk("pre_reset_duty", int'(duty_out), 3);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({led_out, period_done, duty_out}), 0);
        repeat (3) cyc(1'b1, 1'b1);
        sys_rst_n = 1'b1;
        cyc(1'b0, 1'b1);
        repeat (40) cyc(1'b1, 1'b1);
        chk("post_reset_duty", int'(duty_out), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
